rv32i_core: RTL and testbench
=============================

// Module: rv32i_core
// PURPOSE
//  Single-cycle RV32I + Zicsr (machine mode only) processor with an internal unified byte memory.
//  Top of the simulation hierarchy: runs riscv-tests (rv32ui-p-*) images preloaded into memory.
//  Results are read hierarchically through pc, rs[] and csr[]; there are no data ports.
//  Pass criterion: pc reaches 0x44 with rs[3]==1.
// PARAMETERS
//  MEM_BYTES  65536  byte depth of the internal memory
//  RESET_PC   32'h0  pc value loaded on reset
// PORTS
//  clk  in  1  single clock; all state updates on posedge
//  rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
// BEHAVIOUR
//  Hierarchy (fixed names, accessed by benches):
//  - submodule instance `memory` with array `m[0:MEM_BYTES-1]` of 8 bits
//  - `pc` (32b); `rs[0:31]` (32b GPRs); `csr[0:4095]` (32b)
//  Memory is byte-addressed and little-endian; addr wraps modulo MEM_BYTES.
//  Fetch: 32-bit, combinational read of m[pc..pc+3].
//  Data reads: combinational. Writes: on posedge.
//  Memory contents are NOT cleared by reset, so a $readmemh preload survives.
//  Reset (rst==0 at posedge): pc<=RESET_PC; rs[*]<=0; csr[*]<=0; no instruction retires.
//  Run (rst==1): exactly one instruction retires per posedge (CPI=1), updating pc/rs/csr/memory.
//  rs[0] reads 0 always; writes to it are discarded.
//  ISA: LUI AUIPC JAL JALR, BEQ BNE BLT BGE BLTU BGEU, LB LH LW LBU LHU, SB SH SW,
//   all OP-IMM/OP ALU ops (shift amount = low 5 bits), FENCE = nop.
//  Arithmetic: 32-bit wrap. BLT/BGE are signed; BLTU/BGEU are unsigned. BGE is taken on equality.
//  Branches/jumps: target = pc+sext(imm); JALR target = (rs1+imm)&~1. rd gets pc+4, computed before rs1 changes.
//  Loads: LB/LH sign-extend; LBU/LHU zero-extend. Misaligned data access is allowed (byte memory).
//  CSR ops: CSRRW/S/C and the I variants operate on csr[addr[11:0]]; rd gets the old value.
//  - CSRRS/C with rs1=x0 (or zimm=0) do not write.
//  - All 4096 entries are read/write storage. mhartid (0xF14) reads 0.
//  ECALL: csr[0x341]<=pc; csr[0x342]<=11; pc<=csr[0x305]&~3.
//  EBREAK: same, with mcause 3.
//  Illegal/unsupported opcode: same, with mcause 2 and csr[0x343]<=instr.
//  MRET: pc<=csr[0x341].
//  Simultaneous rd==rs1: operand uses the pre-instruction value.
//  Reset asserted mid-program wins over execution at that edge.
// CONFIGURATION
//  CORE_TRACE_EN defined: each retiring edge does $display("%h %h", pc, instr),
//   plus rd/value when rd!=0 is written.
//  CORE_TRACE_EN undefined: no display output; architectural behaviour identical.
// TESTING
//  1 Reset: rst=0 for 1 edge -> pc==0, rs[3]==0, csr[0x305]==0; memory preload intact.
//  2 BGE: x1=-1, x2=-1, bge x1,x2,+8 -> taken. x1=-2, x2=-1 -> not taken, pc+4.
//    BGEU with x1=0xFFFFFFFF, x2=1 -> taken.
//  3 Load/store: sw 0x80FF7F01 at 0x100; then lb 0x101 -> 0x0000007F, lb 0x103 -> 0xFFFFFF80,
//    lhu 0x102 -> 0x80FF, lw -> 0x80FF7F01.
//  4 Trap: csrw mtvec,0x4; ecall at 0x20 -> pc==0x4, mepc==0x20, mcause==11.
//    mepc=0x24 then mret -> pc==0x24.
//  5 x0/JALR: addi x0,x0,5 -> rs[0]==0. jalr x1,0x41(x1)
//    -> pc==(old x1+0x41)&~1, x1==pc+4.
//  6 Full image: load rv32ui-p-bge.hex, release reset -> pc==0x44 with rs[3]==1 within 5000 cycles.

Source files
------------

// File: rtl/rv32i_core_if.sv
// Internal instruction/data bus between the rv32i_core datapath and its unified byte memory.
// Fetch and data reads are combinational; byte-enabled writes land on the next clock edge.
interface rv32i_core_if;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic [31:0] daddr;
  logic [31:0] drdata;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        dwe;

  modport master (
    output iaddr,
    input  irdata,
    output daddr,
    input  drdata,
    output dwdata,
    output dbe,
    output dwe
  );

  modport slave (
    input  iaddr,
    output irdata,
    input  daddr,
    output drdata,
    input  dwdata,
    input  dbe,
    input  dwe
  );
endinterface

// File: rtl/rv32i_core.sv
// Single-cycle RV32I + Zicsr (M-mode) core with a unified little-endian byte memory.
// Define CORE_TRACE_EN to print a retirement trace (pc, instr, rd writes).

module rv32i_core_mem #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input logic          clk,
  rv32i_core_if.slave  bus
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  // Not reset, so a preload survives reset.
  logic [7:0] m [0:MEM_BYTES-1];

  function automatic logic [AW-1:0] wrap(input logic [31:0] a, input int k);
    return a[AW-1:0] + AW'(k);
  endfunction

  always_comb begin
    bus.irdata = '0;
    bus.drdata = '0;
    for (int k = 0; k < 4; k++) begin
      bus.irdata[8*k +: 8] = m[wrap(bus.iaddr, k)];
      bus.drdata[8*k +: 8] = m[wrap(bus.daddr, k)];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.dwe) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.dbe[k]) m[wrap(bus.daddr, k)] <= bus.dwdata[8*k +: 8];
      end
    end
  end

  logic unused_hi;
  assign unused_hi = ^{bus.iaddr[31:AW], bus.daddr[31:AW]};
endmodule

module rv32i_core #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpFence  = 7'h0f;
  localparam logic [6:0] OpSystem = 7'h73;

  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;
  localparam logic [11:0] CsrMhartid = 12'hF14;

  rv32i_core_if bus ();

  rv32i_core_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) memory (
    .clk (clk),
    .bus (bus)
  );

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] csr_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rv1, rv2, csr_old, csr_src;

  assign bus.iaddr = pc;
  assign instr     = bus.irdata;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign f3        = instr[14:12];
  assign rs1a      = instr[19:15];
  assign rs2a      = instr[24:20];
  assign f7        = instr[31:25];
  assign csr_addr  = instr[31:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Operands are the pre-instruction register values, so rd==rs1 is safe.
  assign rv1     = (rs1a == 5'd0) ? 32'd0 : rs[rs1a];
  assign rv2     = (rs2a == 5'd0) ? 32'd0 : rs[rs2a];
  assign csr_old = (csr_addr == CsrMhartid) ? 32'd0 : csr[csr_addr];
  assign csr_src = f3[2] ? {27'd0, rs1a} : rv1;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0:    r = alt ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] pc_d;
  logic        rd_we;
  logic [31:0] rd_val;
  logic        csr_we;
  logic [31:0] csr_wval;
  logic        trap;
  logic        illegal;
  logic [31:0] cause;
  logic        st_req;
  logic        take;

  always_comb begin
    pc_d       = pc + 32'd4;
    rd_we      = 1'b0;
    rd_val     = '0;
    csr_we     = 1'b0;
    csr_wval   = '0;
    trap       = 1'b0;
    illegal    = 1'b0;
    cause      = '0;
    st_req     = 1'b0;
    take       = 1'b0;
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.dbe    = '0;

    case (opcode)
      OpLui: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OpAuipc: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OpJal: begin
        rd_we  = 1'b1;
        rd_val = pc + 32'd4;
        pc_d   = pc + imm_j;
      end
      OpJalr: begin
        if (f3 != 3'd0) begin
          illegal = 1'b1;
        end else begin
          rd_we  = 1'b1;
          rd_val = pc + 32'd4;
          pc_d   = (rv1 + imm_i) & ~32'd1;
        end
      end
      OpBranch: begin
        case (f3)
          3'd0:    take = (rv1 == rv2);
          3'd1:    take = (rv1 != rv2);
          3'd4:    take = ($signed(rv1) < $signed(rv2));
          3'd5:    take = ($signed(rv1) >= $signed(rv2));
          3'd6:    take = (rv1 < rv2);
          3'd7:    take = (rv1 >= rv2);
          default: illegal = 1'b1;
        endcase
        if (take) pc_d = pc + imm_b;
      end
      OpLoad: begin
        bus.daddr = rv1 + imm_i;
        rd_we     = 1'b1;
        case (f3)
          3'd0:    rd_val = {{24{bus.drdata[7]}}, bus.drdata[7:0]};
          3'd1:    rd_val = {{16{bus.drdata[15]}}, bus.drdata[15:0]};
          3'd2:    rd_val = bus.drdata;
          3'd4:    rd_val = {24'd0, bus.drdata[7:0]};
          3'd5:    rd_val = {16'd0, bus.drdata[15:0]};
          default: illegal = 1'b1;
        endcase
      end
      OpStore: begin
        bus.daddr = rv1 + imm_s;
        st_req    = 1'b1;
        case (f3)
          3'd0: begin
            bus.dbe    = 4'b0001;
            bus.dwdata = {4{rv2[7:0]}};
          end
          3'd1: begin
            bus.dbe    = 4'b0011;
            bus.dwdata = {2{rv2[15:0]}};
          end
          3'd2: begin
            bus.dbe    = 4'b1111;
            bus.dwdata = rv2;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpImm: begin
        rd_we  = 1'b1;
        rd_val = alu(f3, (f3 == 3'd5) && instr[30], rv1, imm_i);
        if (f3 == 3'd1 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
      end
      OpReg: begin
        rd_we  = 1'b1;
        rd_val = alu(f3, instr[30], rv1, rv2);
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) illegal = 1'b1;
      end
      OpFence: ;
      OpSystem: begin
        if (f3 == 3'd0) begin
          if (instr == 32'h0000_0073) begin
            trap  = 1'b1;
            cause = 32'd11;
          end else if (instr == 32'h0010_0073) begin
            trap  = 1'b1;
            cause = 32'd3;
          end else if (instr == 32'h3020_0073) begin
            pc_d = csr[CsrMepc];
          end else begin
            illegal = 1'b1;
          end
        end else if (f3 == 3'd4) begin
          illegal = 1'b1;
        end else begin
          rd_we  = 1'b1;
          rd_val = csr_old;
          // Set/clear with a zero source (x0 or zimm=0) is a pure read.
          case (f3[1:0])
            2'd1: begin
              csr_we   = 1'b1;
              csr_wval = csr_src;
            end
            2'd2: begin
              csr_we   = (rs1a != 5'd0);
              csr_wval = csr_old | csr_src;
            end
            default: begin
              csr_we   = (rs1a != 5'd0);
              csr_wval = csr_old & ~csr_src;
            end
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      trap  = 1'b1;
      cause = 32'd2;
    end

    if (trap) begin
      pc_d   = {csr[CsrMtvec][31:2], 2'b00};
      rd_we  = 1'b0;
      csr_we = 1'b0;
      st_req = 1'b0;
    end
  end

  // Reset is synchronous, so gating here keeps memory untouched on a reset edge.
  assign bus.dwe = st_req & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= '0;
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    end else begin
      pc <= pc_d;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
      if (csr_we) csr[csr_addr] <= csr_wval;
      if (trap) begin
        csr[CsrMepc]   <= pc;
        csr[CsrMcause] <= cause;
        if (illegal) csr[CsrMtval] <= instr;
      end
    end
  end

`ifdef CORE_TRACE_EN
  always @(posedge clk) begin
    if (rst) begin
      $display("%h %h", pc, instr);
      if (rd_we && rd != 5'd0) $display("x%0d %h", rd, rd_val);
    end
  end
`else
  // Trace disabled: the core produces no simulation output.
`endif
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: programs are poked into memory, expectations are queued
// on a scoreboard before each run and popped against architectural state afterwards.
module tb_rv32i_core;
  logic clk;
  logic rst;

  rv32i_core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return i_t(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  task automatic put(input logic [15:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.memory.m[a + 16'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] peek(input logic [15:0] a);
    return {dut.memory.m[a + 16'd3], dut.memory.m[a + 16'd2],
            dut.memory.m[a + 16'd1], dut.memory.m[a]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] JSelf = 32'h0000_006f;  // jal x0,0

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: state cleared mid-program, memory preload kept.
    put(16'h200, 32'hDEAD_BEEF);
    put(16'h000, addi(5'd3, 5'd0, 12'd7));
    put(16'h004, i_t(12'h305, 5'd3, 3'd1, 5'd0, 7'h73));
    put(16'h008, JSelf);
    sb_push("pre_x3", 32'd7);
    sb_push("pre_mtvec", 32'd7);
    run(3);
    chk(dut.rs[3]);
    chk(dut.csr[12'h305]);
    sb_push("rst_pc", 32'h0);
    sb_push("rst_x3", 32'h0);
    sb_push("rst_mtvec", 32'h0);
    sb_push("rst_mem", 32'hDEAD_BEEF);
    do_reset();
    chk(dut.pc);
    chk(dut.rs[3]);
    chk(dut.csr[12'h305]);
    chk(peek(16'h200));

    // BGE / BGEU.
    do_reset();
    put(16'h000, addi(5'd1, 5'd0, 12'hFFF));
    put(16'h004, addi(5'd2, 5'd0, 12'hFFF));
    put(16'h008, b_t(13'd8, 5'd2, 5'd1, 3'd5));
    put(16'h00c, addi(5'd5, 5'd0, 12'd1));
    put(16'h010, addi(5'd1, 5'd0, 12'hFFE));
    put(16'h014, b_t(13'd8, 5'd2, 5'd1, 3'd5));
    put(16'h018, addi(5'd6, 5'd0, 12'd1));
    put(16'h01c, addi(5'd1, 5'd0, 12'hFFF));
    put(16'h020, addi(5'd2, 5'd0, 12'd1));
    put(16'h024, b_t(13'd8, 5'd2, 5'd1, 3'd7));
    put(16'h028, addi(5'd7, 5'd0, 12'd1));
    put(16'h02c, JSelf);
    sb_push("bge_eq_pc", 32'h10);
    run(3);
    chk(dut.pc);
    sb_push("bge_lt_pc", 32'h18);
    run(2);
    chk(dut.pc);
    sb_push("bgeu_pc", 32'h2c);
    sb_push("bge_skip_x5", 32'h0);
    sb_push("bge_fall_x6", 32'h1);
    sb_push("bgeu_skip_x7", 32'h0);
    run(4);
    chk(dut.pc);
    chk(dut.rs[5]);
    chk(dut.rs[6]);
    chk(dut.rs[7]);

    // Loads and stores, including misaligned access.
    do_reset();
    put(16'h104, 32'h0);
    put(16'h000, {20'h80FF8, 5'd1, 7'h37});
    put(16'h004, addi(5'd1, 5'd1, 12'hF01));
    put(16'h008, addi(5'd2, 5'd0, 12'h100));
    put(16'h00c, s_t(12'd0, 5'd1, 5'd2, 3'd2));
    put(16'h010, i_t(12'd1, 5'd2, 3'd0, 5'd3, 7'h03));
    put(16'h014, i_t(12'd3, 5'd2, 3'd0, 5'd4, 7'h03));
    put(16'h018, i_t(12'd2, 5'd2, 3'd5, 5'd5, 7'h03));
    put(16'h01c, i_t(12'd0, 5'd2, 3'd2, 5'd6, 7'h03));
    put(16'h020, i_t(12'd1, 5'd2, 3'd2, 5'd7, 7'h03));
    put(16'h024, i_t(12'd2, 5'd2, 3'd1, 5'd8, 7'h03));
    put(16'h028, JSelf);
    sb_push("lb_101", 32'h0000_007F);
    sb_push("lb_103", 32'hFFFF_FF80);
    sb_push("lhu_102", 32'h0000_80FF);
    sb_push("lw_100", 32'h80FF_7F01);
    sb_push("lw_101", 32'h0080_FF7F);
    sb_push("lh_102", 32'hFFFF_80FF);
    sb_push("sw_mem", 32'h80FF_7F01);
    run(11);
    chk(dut.rs[3]);
    chk(dut.rs[4]);
    chk(dut.rs[5]);
    chk(dut.rs[6]);
    chk(dut.rs[7]);
    chk(dut.rs[8]);
    chk(peek(16'h100));

    // ECALL / MRET and CSR read semantics.
    do_reset();
    put(16'h000, j_t(21'h10, 5'd0));
    put(16'h004, addi(5'd9, 5'd0, 12'h024));
    put(16'h008, i_t(12'h341, 5'd9, 3'd1, 5'd0, 7'h73));
    put(16'h00c, 32'h3020_0073);
    put(16'h010, addi(5'd1, 5'd0, 12'd4));
    put(16'h014, i_t(12'h305, 5'd1, 3'd1, 5'd0, 7'h73));
    put(16'h018, j_t(21'h8, 5'd0));
    put(16'h01c, 32'h0000_0013);
    put(16'h020, 32'h0000_0073);
    put(16'h024, addi(5'd10, 5'd0, 12'd1));
    put(16'h028, i_t(12'h305, 5'd0, 3'd2, 5'd11, 7'h73));
    put(16'h02c, i_t(12'h305, 5'd0, 3'd7, 5'd12, 7'h73));
    put(16'h030, i_t(12'hF14, 5'd1, 3'd1, 5'd0, 7'h73));
    put(16'h034, i_t(12'hF14, 5'd0, 3'd2, 5'd13, 7'h73));
    put(16'h038, JSelf);
    sb_push("ecall_pc", 32'h4);
    sb_push("ecall_mepc", 32'h20);
    sb_push("ecall_mcause", 32'd11);
    run(5);
    chk(dut.pc);
    chk(dut.csr[12'h341]);
    chk(dut.csr[12'h342]);
    sb_push("mret_pc", 32'h24);
    run(3);
    chk(dut.pc);
    sb_push("after_mret_x10", 32'd1);
    sb_push("csrrs_x0_old", 32'd4);
    sb_push("csrrci_0_old", 32'd4);
    sb_push("csr_unwritten", 32'd4);
    sb_push("mhartid_zero", 32'd0);
    run(6);
    chk(dut.rs[10]);
    chk(dut.rs[11]);
    chk(dut.rs[12]);
    chk(dut.csr[12'h305]);
    chk(dut.rs[13]);

    // Illegal instruction then EBREAK, with mtvec low bits masked.
    do_reset();
    put(16'h000, addi(5'd1, 5'd0, 12'h043));
    put(16'h004, i_t(12'h305, 5'd1, 3'd1, 5'd0, 7'h73));
    put(16'h008, 32'hFFFF_FFFF);
    put(16'h040, 32'h0010_0073);
    sb_push("ill_pc", 32'h40);
    sb_push("ill_mcause", 32'd2);
    sb_push("ill_mepc", 32'h8);
    sb_push("ill_mtval", 32'hFFFF_FFFF);
    run(3);
    chk(dut.pc);
    chk(dut.csr[12'h342]);
    chk(dut.csr[12'h341]);
    chk(dut.csr[12'h343]);
    sb_push("ebreak_pc", 32'h40);
    sb_push("ebreak_mcause", 32'd3);
    sb_push("ebreak_mepc", 32'h40);
    run(1);
    chk(dut.pc);
    chk(dut.csr[12'h342]);
    chk(dut.csr[12'h341]);

    // x0 immutability and JALR with rd==rs1.
    do_reset();
    put(16'h000, addi(5'd0, 5'd0, 12'd5));
    put(16'h004, addi(5'd1, 5'd0, 12'h100));
    put(16'h008, i_t(12'h041, 5'd1, 3'd0, 5'd1, 7'h67));
    put(16'h140, JSelf);
    sb_push("x0_zero", 32'h0);
    sb_push("jalr_pc", 32'h140);
    sb_push("jalr_link", 32'hC);
    run(3);
    chk(dut.rs[0]);
    chk(dut.pc);
    chk(dut.rs[1]);

    // ALU register/immediate ops.
    do_reset();
    put(16'h000, addi(5'd1, 5'd0, 12'hFF0));
    put(16'h004, addi(5'd2, 5'd0, 12'd3));
    put(16'h008, r_t(7'h20, 5'd2, 5'd1, 3'd5, 5'd3));
    put(16'h00c, r_t(7'h00, 5'd2, 5'd1, 3'd5, 5'd4));
    put(16'h010, r_t(7'h20, 5'd1, 5'd2, 3'd0, 5'd5));
    put(16'h014, r_t(7'h00, 5'd1, 5'd2, 3'd3, 5'd6));
    put(16'h018, r_t(7'h00, 5'd1, 5'd2, 3'd2, 5'd7));
    put(16'h01c, i_t(12'h0FF, 5'd1, 3'd4, 5'd8, 7'h13));
    put(16'h020, {20'h00001, 5'd9, 7'h17});
    put(16'h024, i_t(12'h004, 5'd2, 3'd1, 5'd10, 7'h13));
    put(16'h028, r_t(7'h00, 5'd2, 5'd1, 3'd6, 5'd11));
    put(16'h02c, r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd12));
    put(16'h030, JSelf);
    sb_push("sra", 32'hFFFF_FFFE);
    sb_push("srl", 32'h1FFF_FFFE);
    sb_push("sub", 32'h0000_0013);
    sb_push("sltu", 32'h1);
    sb_push("slt", 32'h0);
    sb_push("xori", 32'hFFFF_FF0F);
    sb_push("auipc", 32'h0000_1020);
    sb_push("slli", 32'h30);
    sb_push("or", 32'hFFFF_FFF3);
    sb_push("and", 32'h0);
    run(13);
    chk(dut.rs[3]);
    chk(dut.rs[4]);
    chk(dut.rs[5]);
    chk(dut.rs[6]);
    chk(dut.rs[7]);
    chk(dut.rs[8]);
    chk(dut.rs[9]);
    chk(dut.rs[10]);
    chk(dut.rs[11]);
    chk(dut.rs[12]);

    // Pass-style program: loop, set x3=1, park at 0x44 (bounded wait).
    do_reset();
    put(16'h000, addi(5'd5, 5'd0, 12'd10));
    put(16'h004, addi(5'd5, 5'd5, 12'hFFF));
    put(16'h008, b_t(13'h1FFC, 5'd0, 5'd5, 3'd1));
    put(16'h00c, addi(5'd3, 5'd0, 12'd1));
    put(16'h010, j_t(21'h34, 5'd0));
    put(16'h044, JSelf);
    sb_push("pass_pc", 32'h44);
    sb_push("pass_x3", 32'h1);
    rst = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (dut.pc == 32'h44) break;
      @(posedge clk);
      #1;
    end
    chk(dut.pc);
    chk(dut.rs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
